// File: rtl/issue_queue.sv
// issue_queue: out-of-order issue queue between rename/dispatch and execute.
// Holds up to DEPTH renamed instructions and tracks readiness of two source
// tags per entry through tag-broadcast wakeup. Each cycle it issues the oldest
// ready entry, using an age matrix so selection never depends on entry index.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    dispatch handshake (in_ready = count<DEPTH && !flush)
//   in_payload, in_src*  instruction payload, source tags and ready bits
//   in_al_idx            active-list slot of the dispatched instruction
//   wk_valid/wk_tag      per-port wakeup broadcasts
//   iss_valid/iss_ready  issue handshake; iss_payload/iss_al_idx of selected entry
//   flush                discard all entries this edge
//   count                number of valid entries (registered)
module issue_queue #(
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned PTAG_W    = 6,
    parameter int unsigned PAYLOAD_W = 128,
    parameter int unsigned AL_IDX_W  = 5,
    parameter int unsigned WK_PORTS  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PAYLOAD_W-1:0]       in_payload,
    input  logic [PTAG_W-1:0]          in_src1_tag,
    input  logic [PTAG_W-1:0]          in_src2_tag,
    input  logic                       in_src1_rdy,
    input  logic                       in_src2_rdy,
    input  logic [AL_IDX_W-1:0]        in_al_idx,
    input  logic [WK_PORTS-1:0]        wk_valid,
    input  logic [WK_PORTS*PTAG_W-1:0] wk_tag,
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output logic [PAYLOAD_W-1:0]       iss_payload,
    output logic [AL_IDX_W-1:0]        iss_al_idx,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    // Control state (reset)
    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0]            rdy1_q, rdy1_d;
    logic [DEPTH-1:0]            rdy2_q, rdy2_d;
    // older_q[j][i] = 1 when entry j was allocated before entry i
    logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;
    logic [CNT_W-1:0]            count_q, count_d;

    // Data state (no reset; only read through a valid grant)
    logic [PTAG_W-1:0]    tag1_q    [DEPTH];
    logic [PTAG_W-1:0]    tag2_q    [DEPTH];
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];
    logic [AL_IDX_W-1:0]  al_idx_q  [DEPTH];

    logic [DEPTH-1:0] cand;
    logic [DEPTH-1:0] grant;
    logic [IDX_W-1:0] alloc_idx;
    logic             alloc_found;
    logic             do_ins;
    logic             do_iss;

    // True when any valid wakeup port carries the given tag
    function automatic logic tag_hit(input logic [PTAG_W-1:0]          tag,
                                     input logic [WK_PORTS-1:0]        v,
                                     input logic [WK_PORTS*PTAG_W-1:0] t);
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < int'(WK_PORTS); p++) begin
            if (v[p] && (t[p*PTAG_W +: PTAG_W] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    assign in_ready = (count_q < CNT_W'(DEPTH)) && !flush;
    assign count    = count_q;
    assign do_ins   = in_valid && in_ready && alloc_found;
    assign do_iss   = iss_valid && iss_ready;

    // Lowest-index free entry
    always_comb begin
        alloc_idx   = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (!valid_q[i] && !alloc_found) begin
                alloc_idx   = IDX_W'(i);
                alloc_found = 1'b1;
            end
        end
    end

    // Oldest-ready select: a candidate wins unless an older candidate exists
    always_comb begin
        cand        = valid_q & rdy1_q & rdy2_q;
        grant       = '0;
        iss_payload = '0;
        iss_al_idx  = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            grant[i] = cand[i];
            for (int j = 0; j < int'(DEPTH); j++) begin
                if (cand[j] && older_q[j][i]) grant[i] = 1'b0;
            end
        end
        if (flush) grant = '0;
        iss_valid = |grant;
        // grant is one-hot, so an AND-OR mux suffices
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (grant[i]) begin
                iss_payload = iss_payload | payload_q[i];
                iss_al_idx  = iss_al_idx | al_idx_q[i];
            end
        end
    end

    // Next-state: wakeup, issue, allocate, flush
    always_comb begin
        valid_d = valid_q;
        rdy1_d  = rdy1_q;
        rdy2_d  = rdy2_q;
        older_d = older_q;
        count_d = count_q;

        for (int i = 0; i < int'(DEPTH); i++) begin
            if (tag_hit(tag1_q[i], wk_valid, wk_tag)) rdy1_d[i] = 1'b1;
            if (tag_hit(tag2_q[i], wk_valid, wk_tag)) rdy2_d[i] = 1'b1;
        end

        if (do_iss) valid_d = valid_d & ~grant;

        if (do_ins) begin
            valid_d[alloc_idx] = 1'b1;
            rdy1_d[alloc_idx]  = in_src1_rdy | tag_hit(in_src1_tag, wk_valid, wk_tag);
            rdy2_d[alloc_idx]  = in_src2_rdy | tag_hit(in_src2_tag, wk_valid, wk_tag);
            // New entry is younger than every other entry
            older_d[alloc_idx] = '0;
            for (int j = 0; j < int'(DEPTH); j++) begin
                if (IDX_W'(j) != alloc_idx) older_d[j][alloc_idx] = 1'b1;
            end
        end

        case ({do_ins, do_iss})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (flush) begin
            valid_d = '0;
            count_d = '0;
        end
    end

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
            older_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            rdy1_q  <= rdy1_d;
            rdy2_q  <= rdy2_d;
            older_q <= older_d;
            count_q <= count_d;
        end
    end

    // Entry data written on allocation
    always_ff @(posedge clk) begin
        if (do_ins) begin
            tag1_q[alloc_idx]    <= in_src1_tag;
            tag2_q[alloc_idx]    <= in_src2_tag;
            payload_q[alloc_idx] <= in_payload;
            al_idx_q[alloc_idx]  <= in_al_idx;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: age-ordered list model plus directed scenarios.
module tb_issue_queue;

    localparam int unsigned DEPTH     = 32;
    localparam int unsigned PTAG_W    = 6;
    localparam int unsigned PAYLOAD_W = 128;
    localparam int unsigned AL_IDX_W  = 5;
    localparam int unsigned WK_PORTS  = 2;
    localparam int unsigned CNT_W     = $clog2(DEPTH+1);

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       in_valid = 1'b0;
    logic                       in_ready;
    logic [PAYLOAD_W-1:0]       in_payload = '0;
    logic [PTAG_W-1:0]          in_src1_tag = '0;
    logic [PTAG_W-1:0]          in_src2_tag = '0;
    logic                       in_src1_rdy = 1'b0;
    logic                       in_src2_rdy = 1'b0;
    logic [AL_IDX_W-1:0]        in_al_idx = '0;
    logic [WK_PORTS-1:0]        wk_valid = '0;
    logic [WK_PORTS*PTAG_W-1:0] wk_tag = '0;
    logic                       iss_valid;
    logic                       iss_ready = 1'b0;
    logic [PAYLOAD_W-1:0]       iss_payload;
    logic [AL_IDX_W-1:0]        iss_al_idx;
    logic                       flush = 1'b0;
    logic [CNT_W-1:0]           count;

    always #5 clk = ~clk;

    issue_queue #(
        .DEPTH(DEPTH), .PTAG_W(PTAG_W), .PAYLOAD_W(PAYLOAD_W),
        .AL_IDX_W(AL_IDX_W), .WK_PORTS(WK_PORTS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
        .in_src1_tag(in_src1_tag), .in_src2_tag(in_src2_tag),
        .in_src1_rdy(in_src1_rdy), .in_src2_rdy(in_src2_rdy),
        .in_al_idx(in_al_idx), .wk_valid(wk_valid), .wk_tag(wk_tag),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_payload(iss_payload), .iss_al_idx(iss_al_idx),
        .flush(flush), .count(count)
    );

    // Model: queue kept in allocation order, oldest at the front
    typedef struct {
        logic [PAYLOAD_W-1:0] pl;
        logic [AL_IDX_W-1:0]  al;
        logic [PTAG_W-1:0]    t1;
        logic [PTAG_W-1:0]    t2;
        logic                 r1;
        logic                 r2;
    } ent_t;

    ent_t                mq[$];
    logic [AL_IDX_W-1:0] dut_log[$];
    int                  checks = 0;
    int                  errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic wk_hit(input logic [PTAG_W-1:0] t);
        for (int p = 0; p < int'(WK_PORTS); p++)
            if (wk_valid[p] && wk_tag[p*PTAG_W +: PTAG_W] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int oldest_ready();
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].r1 && mq[i].r2) return i;
        return -1;
    endfunction

    function automatic logic [PAYLOAD_W-1:0] mkpl(input logic [AL_IDX_W-1:0] al);
        return {8'h5A, 112'h0, 3'b101, al};
    endfunction

    // Model update at each edge
    int   m_sel;
    logic m_room;
    ent_t m_new;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
        end else if (flush) begin
            mq.delete();
        end else begin
            m_room = (mq.size() < int'(DEPTH));
            m_sel  = oldest_ready();
            if (m_sel >= 0 && iss_ready) mq.delete(m_sel);
            for (int i = 0; i < mq.size(); i++) begin
                if (wk_hit(mq[i].t1)) mq[i].r1 = 1'b1;
                if (wk_hit(mq[i].t2)) mq[i].r2 = 1'b1;
            end
            if (in_valid && m_room) begin
                m_new.pl = in_payload;
                m_new.al = in_al_idx;
                m_new.t1 = in_src1_tag;
                m_new.t2 = in_src2_tag;
                m_new.r1 = in_src1_rdy | wk_hit(in_src1_tag);
                m_new.r2 = in_src2_rdy | wk_hit(in_src2_tag);
                mq.push_back(m_new);
            end
        end
    end

    // Compare every cycle, mid-period
    int                   c_sel;
    logic [AL_IDX_W-1:0]  c_al;
    logic [PAYLOAD_W-1:0] c_pl;
    always @(negedge clk) begin
        if (rst_n) begin
            c_sel = flush ? -1 : oldest_ready();
            c_al  = '0;
            c_pl  = '0;
            if (c_sel >= 0) begin
                c_al = mq[c_sel].al;
                c_pl = mq[c_sel].pl;
            end
            chk("in_ready",    128'(in_ready),    128'((mq.size() < int'(DEPTH)) && !flush));
            chk("iss_valid",   128'(iss_valid),   128'(c_sel >= 0));
            chk("iss_al_idx",  128'(iss_al_idx),  128'(c_al));
            chk("iss_payload", 128'(iss_payload), 128'(c_pl));
            chk("count",       128'(count),       128'(mq.size()));
            if (iss_valid && iss_ready) dut_log.push_back(iss_al_idx);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        wk_valid = '0;
        flush    = 1'b0;
    endtask

    task automatic ins(input logic [AL_IDX_W-1:0] al,
                       input logic [PTAG_W-1:0] t1, input logic r1,
                       input logic [PTAG_W-1:0] t2, input logic r2);
        in_valid    = 1'b1;
        in_al_idx   = al;
        in_payload  = mkpl(al);
        in_src1_tag = t1;
        in_src1_rdy = r1;
        in_src2_tag = t2;
        in_src2_rdy = r2;
    endtask

    int log_n;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_count",     128'(count),     128'd0);
        chk("reset_iss_valid", 128'(iss_valid), 128'd0);
        chk("reset_in_ready",  128'(in_ready),  128'd1);

        // Three ready inserts issue back-to-back, one cycle after insert
        iss_ready = 1'b1;
        tick(); ins(5'd5, 6'd0, 1'b1, 6'd0, 1'b1);
        tick(); ins(5'd6, 6'd0, 1'b1, 6'd0, 1'b1);
        @(negedge clk); chk("t1_iss5", 128'(iss_al_idx), 128'd5);
        tick(); ins(5'd7, 6'd0, 1'b1, 6'd0, 1'b1);
        @(negedge clk); chk("t1_iss6", 128'(iss_al_idx), 128'd6);
        tick(); idle();
        @(negedge clk); chk("t1_iss7", 128'(iss_al_idx), 128'd7);
        tick();
        @(negedge clk); chk("t1_count0", 128'(count), 128'd0);

        // Fill the queue with entries waiting on tag 9
        for (int i = 0; i < int'(DEPTH); i++) begin
            ins(5'(i), 6'd9, 1'b0, 6'd0, 1'b1);
            tick();
        end
        ins(5'd30, 6'd0, 1'b1, 6'd0, 1'b1);
        @(negedge clk);
        chk("t2_full_in_ready", 128'(in_ready),  128'd0);
        chk("t2_full_count",    128'(count),     128'd32);
        chk("t2_full_iss",      128'(iss_valid), 128'd0);
        tick(); idle();
        dut_log.delete();
        wk_valid = 2'b10;
        wk_tag   = {6'd9, 6'd0};
        tick(); idle();
        @(negedge clk);
        chk("t2_wake_iss",   128'(iss_valid),  128'd1);
        chk("t2_wake_al",    128'(iss_al_idx), 128'd0);
        chk("t2_still_full", 128'(in_ready),   128'd0);
        tick();
        @(negedge clk);
        chk("t2_room",  128'(in_ready), 128'd1);
        chk("t2_cnt31", 128'(count),    128'd31);
        for (int k = 0; k < 40 && count != '0; k++) tick();
        chk("t2_drained", 128'(count), 128'd0);
        chk("t2_log_n",   128'(dut_log.size()), 128'd32);
        if (dut_log.size() == 32) chk("t2_log_last", 128'(dut_log[31]), 128'd31);

        // A (pending tag 12) stays older than C even though C was ready first
        ins(5'd1, 6'd12, 1'b0, 6'd0, 1'b1);
        tick(); ins(5'd2, 6'd0, 1'b1, 6'd0, 1'b1);
        tick(); idle();
        @(negedge clk); chk("t3_issB", 128'(iss_al_idx), 128'd2);
        tick(); iss_ready = 1'b0; ins(5'd3, 6'd0, 1'b1, 6'd0, 1'b1);
        tick(); idle();
        wk_valid = 2'b01;
        wk_tag   = {6'd0, 6'd12};
        @(negedge clk); chk("t3_onlyC", 128'(iss_al_idx), 128'd3);
        tick(); idle();
        @(negedge clk); chk("t3_A_first", 128'(iss_al_idx), 128'd1);
        iss_ready = 1'b1;
        tick();
        @(negedge clk); chk("t3_C_next", 128'(iss_al_idx), 128'd3);
        tick();

        // Older entry at a higher index must still win
        iss_ready = 1'b0;
        ins(5'd20, 6'd0, 1'b1, 6'd0, 1'b1);
        tick(); ins(5'd21, 6'd14, 1'b0, 6'd0, 1'b1);
        tick(); idle(); iss_ready = 1'b1;
        @(negedge clk); chk("t3b_X", 128'(iss_al_idx), 128'd20);
        tick(); iss_ready = 1'b0; ins(5'd22, 6'd14, 1'b0, 6'd0, 1'b1);
        tick(); idle();
        wk_valid = 2'b01;
        wk_tag   = {6'd0, 6'd14};
        tick(); idle();
        @(negedge clk); chk("t3b_Y_older", 128'(iss_al_idx), 128'd21);
        iss_ready = 1'b1;
        tick();
        @(negedge clk); chk("t3b_Z", 128'(iss_al_idx), 128'd22);
        tick();

        // Same-cycle wakeup bypass on insert
        ins(5'd8, 6'd0, 1'b1, 6'd20, 1'b0);
        wk_valid = 2'b01;
        wk_tag   = {6'd0, 6'd20};
        tick(); idle();
        @(negedge clk);
        chk("t4_bypass_v",  128'(iss_valid),  128'd1);
        chk("t4_bypass_al", 128'(iss_al_idx), 128'd8);
        tick();

        // Flush with 10 valid entries
        iss_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ins(5'(10 + i), 6'd0, 1'b1, 6'd0, 1'b1);
            tick();
        end
        idle();
        @(negedge clk);
        chk("t5_cnt10", 128'(count),     128'd10);
        chk("t5_iss",   128'(iss_valid), 128'd1);
        tick();
        log_n     = dut_log.size();
        flush     = 1'b1;
        iss_ready = 1'b1;
        ins(5'd30, 6'd0, 1'b1, 6'd0, 1'b1);
        wk_valid  = 2'b11;
        @(negedge clk);
        chk("t5_fl_iss",   128'(iss_valid),   128'd0);
        chk("t5_fl_rdy",   128'(in_ready),    128'd0);
        chk("t5_fl_pl",    128'(iss_payload), 128'd0);
        tick(); idle();
        @(negedge clk);
        chk("t5_cnt0",     128'(count),     128'd0);
        chk("t5_no_iss",   128'(iss_valid), 128'd0);
        chk("t5_no_log",   128'(dut_log.size()), 128'(log_n));

        // Hold, then asynchronous reset mid-hold
        iss_ready = 1'b0;
        ins(5'd9, 6'd0, 1'b1, 6'd0, 1'b1);
        tick(); idle();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t6_hold_al",  128'(iss_al_idx),  128'd9);
            chk("t6_hold_pl",  128'(iss_payload), 128'(mkpl(5'd9)));
            chk("t6_hold_cnt", 128'(count),       128'd1);
            tick();
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_cnt", 128'(count),     128'd0);
        chk("t6_rst_iss", 128'(iss_valid), 128'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t6_post_rdy", 128'(in_ready), 128'd1);
        chk("t6_post_cnt", 128'(count),    128'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
